// File: rtl/nonrestoring_div.sv
// Multi-cycle non-restoring divider: one quotient bit per cycle, then a single fix-up cycle.
// Define DIV_SIGNED_EN for two's-complement operands; leave it undefined for unsigned division.
`timescale 1ns/1ps
module nonrestoring_div #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t                 state, state_next;
    logic [CNT_W-1:0]       count;
    logic signed [WIDTH:0]  part_rem, rem_shift, rem_step, dvs_ext;
    logic [WIDTH-1:0]       work_q, dvs_mag, dvd_load, dvs_load;
    logic [WIDTH-1:0]       rem_fix, q_final, r_final;
    logic                   dvs_zero;
    logic                   accept;

`ifdef DIV_SIGNED_EN
    logic dvd_neg, quo_neg;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign dvd_load = magnitude(dividend);
    assign dvs_load = magnitude(divisor);
    // Zero divisor leaves work_q all ones, but a negative dividend would flip it, so force it.
    assign q_final  = dvs_zero ? '1 : apply_sign(work_q, quo_neg);
    assign r_final  = apply_sign(rem_fix, dvd_neg);
`else
    assign dvd_load = dividend;
    assign dvs_load = divisor;
    assign q_final  = dvs_zero ? '1 : work_q;
    assign r_final  = rem_fix;
`endif

    assign accept = (state == IDLE) && start;

    // The shifted value may wrap in WIDTH+1 bits, but the add/sub result always lands in [-D, D).
    assign dvs_ext   = signed'({1'b0, dvs_mag});
    assign rem_shift = signed'({part_rem[WIDTH-1:0], work_q[WIDTH-1]});
    assign rem_step  = part_rem[WIDTH] ? (rem_shift + dvs_ext) : (rem_shift - dvs_ext);
    assign rem_fix   = part_rem[WIDTH-1:0] + (part_rem[WIDTH] ? dvs_mag : '0);

    assign busy = (state == ITER) || (state == FIX);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ITER;
            ITER:    if (count == CNT_ONE) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                count <= CNT_LOAD;
            end else if (state == ITER) begin
                count <= count - CNT_ONE;
            end
            if (state == FIX) begin
                quotient    <= q_final;
                remainder   <= r_final;
                div_by_zero <= dvs_zero;
            end
        end
    end

    // Working registers carry no reset; they are always reloaded on an accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            part_rem <= '0;
            work_q   <= dvd_load;
            dvs_mag  <= dvs_load;
            dvs_zero <= (divisor == '0);
`ifdef DIV_SIGNED_EN
            dvd_neg  <= dividend[WIDTH-1];
            quo_neg  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
`endif
        end else if (state == ITER) begin
            part_rem <= rem_step;
            work_q   <= {work_q[WIDTH-2:0], ~rem_step[WIDTH]};
        end
    end

endmodule

// File: tb/tb_nonrestoring_div.sv
// Self-checking bench for nonrestoring_div (WIDTH=16); follows the DIV_SIGNED_EN build setting.
`timescale 1ns/1ps
module tb_nonrestoring_div;

    localparam int W   = 16;
    localparam int LAT = W + 2;

    logic         clk, rst_n, start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int n_checks = 0;
    int n_fail   = 0;

    nonrestoring_div #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (n_fail=%0d)", n_fail);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain language-level division on the operand values.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
`ifdef DIV_SIGNED_EN
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (b == 0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            q = W'(sa / sb); r = W'(sa % sb); z = 1'b0;
        end
`else
        if (b == 0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
`endif
    endfunction

    task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                             input bit rel_rst);
        int lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (rel_rst) rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy"}, busy, 1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check({name, "_latency"}, lat, LAT);
        check({name, "_quotient"}, quotient, eq);
        check({name, "_remainder"}, remainder, er);
        check({name, "_dbz"}, div_by_zero, ez);
        @(negedge clk);
        check({name, "_done_pulse"}, done, 0);
    endtask

    initial begin
        logic [W-1:0] a, b, eq, er, cq, cr;
        logic         ez;
        int           lat, ndone;

`ifdef DIV_SIGNED_EN
        vecs[0] = '{16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0};
        vecs[1] = '{16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0};
        vecs[2] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
        vecs[3] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1};
        vecs[4] = '{16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1'b1};
        vecs[5] = '{16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0};
        vecs[6] = '{16'hFFFF, 16'h8000, 16'h0000, 16'hFFFF, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 16'h0001, 16'h0000, 1'b0};
`else
        vecs[0] = '{16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 1'b0};
        vecs[1] = '{16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0};
        vecs[2] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1};
        vecs[3] = '{16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{16'h0005, 16'h0007, 16'h0000, 16'h0005, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0};
        vecs[6] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
        vecs[7] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0};
`endif

        rst_n = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);

        // first accepted start on the first edge after release
        run_check("first_start", 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b1);

        for (int i = 0; i < NV; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs,
                      vecs[i].q, vecs[i].r, vecs[i].z, 1'b0);
        end
        repeat (3) @(negedge clk);
        check("hold_quotient", quotient, vecs[NV-1].q);
        check("hold_remainder", remainder, vecs[NV-1].r);

        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 15));
                3:       b = '1;
                default: b = W'($urandom);
            endcase
            model(a, b, eq, er, ez);
            run_check($sformatf("rand%0d", i), a, b, eq, er, ez, 1'b0);
        end

        // start pulsed with new operands while busy must be ignored
        @(negedge clk);
        dividend = 16'h0064; divisor = 16'h0007; start = 1'b1;
        @(posedge clk);
        ndone = 0; lat = 0; cq = '0; cr = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 5) begin
                dividend = 16'hFFFF; divisor = 16'h0001; start = 1'b1;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    lat = k; cq = quotient; cr = remainder;
                end
            end
        end
        start = 1'b0;
        check("busy_start_ndone", ndone, 1);
        check("busy_start_latency", lat, LAT);
        check("busy_start_quotient", cq, 16'h000E);
        check("busy_start_remainder", cr, 16'h0002);

        // start raised during the DONE cycle is taken only in the following IDLE cycle
        @(negedge clk);
        dividend = 16'h0064; divisor = 16'h0007; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin lat = k; break; end
            @(negedge clk);
        end
        check("done_cycle_first_latency", lat, LAT);
        dividend = 16'h00FF; divisor = 16'h0010; start = 1'b1;
        @(negedge clk);
        check("done_cycle_start_ignored_busy", busy, 0);
        lat = 0;
        for (int k = 2; k <= 45; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin lat = k; break; end
        end
        check("done_cycle_relatency", lat, LAT + 1);
        check("done_cycle_quotient", quotient, 16'h000F);
        check("done_cycle_remainder", remainder, 16'h000F);

        // reset in the middle of an operation
        @(negedge clk);
        dividend = 16'h1234; divisor = 16'h0003; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_quotient", quotient, 0);
        check("midreset_remainder", remainder, 0);
        check("midreset_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midreset_no_done", ndone, 0);
        check("midreset_idle_busy", busy, 0);

        // operation after a mid-run reset completes normally
        model(16'hFFF0, 16'h0011, eq, er, ez);
        run_check("post_reset", 16'hFFF0, 16'h0011, eq, er, ez, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
